// File: rtl/ca_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ca_isa_pkg
// Description : Shared ISA definitions for the instruction fetch path.
//               - instruction and fetch address widths
//               - major opcodes used by fetch pre-decode
//               - fetch_entry_t, the record carried from fetch to decode
//               - is_uncond_jmp(), which recognises the jump fetch follows
// Revision    : 1.0 - initial release
// ============================================================================
package ca_isa_pkg;

    localparam int INS_W  = 19;
    localparam int ADDR_W = 12;

    // Major opcode lives in ins[18:16]
    localparam logic [2:0] OP_LDST = 3'b100;
    localparam logic [2:0] OP_JMP  = 3'b101;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INS_W-1:0]  ins;
    } fetch_entry_t;

    // Only the unconditional form (condition field ins[15:14] == 0) can be
    // followed at fetch time; conditional forms are resolved by execute.
    function automatic logic is_uncond_jmp(input logic [INS_W-1:0] ins);
        return (ins[INS_W-1 -: 3] == OP_JMP) && (ins[INS_W-4 -: 2] == 2'b00);
    endfunction

endpackage : ca_isa_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO of fetch_entry_t between fetch and decode.
//               Supports push and pop in the same cycle even when full, and a
//               flush that empties the queue in one cycle.
// Ports       : clk        in   clock
//               rst        in   synchronous active-high reset
//               flush      in   discard all entries (dominates push/pop)
//               push       in   write push_data at tail
//               push_data  in   entry to write
//               pop        in   advance head
//               head_data  out  entry at head
//               empty      out  no entries held
//               full       out  DEPTH entries held
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import ca_isa_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head_data,
    output logic         empty,
    output logic         full
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t         r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;

    // Storage is cleared on reset so the head presents zeros until the first
    // instruction arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_mem[r_tail] <= push_data;
                // DEPTH is a power of two, so pointers wrap naturally
                r_tail        <= r_tail + c_PTR_W'(1);
            end
            if (pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_data = r_mem[r_head];
    assign empty     = (r_count == '0);
    assign full      = (r_count == c_CNT_W'(DEPTH));

endmodule : fetch_queue
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Requester side of the instruction-memory port. Owns the PC,
//               captures the same-cycle instruction with its PC into a small
//               queue toward decode, follows unconditional jumps at fetch and
//               accepts redirects from execute.
// Ports       : clk             in   clock
//               rst             in   synchronous active-high reset
//               imem_addr       out  fetch address (the PC register)
//               imem_ins        in   instruction at imem_addr, same cycle
//               redirect_valid  in   execute requests a PC change
//               redirect_pc     in   new fetch address
//               deq_valid       out  head instruction available to decode
//               deq_ready       in   decode accepts head
//               deq_ins         out  head instruction
//               deq_pc          out  PC of head instruction
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int                             ADDR_W   = ca_isa_pkg::ADDR_W,
    parameter int                             INS_W    = ca_isa_pkg::INS_W,
    parameter int                             DEPTH    = 2,
    parameter logic [ca_isa_pkg::ADDR_W-1:0]  RESET_PC = 12'd0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INS_W-1:0]  imem_ins,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [INS_W-1:0]  deq_ins,
    output logic [ADDR_W-1:0] deq_pc
);

    import ca_isa_pkg::*;

    logic [ADDR_W-1:0] r_pc;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_enq;
    logic              w_is_jmp;
    fetch_entry_t      w_entry;
    fetch_entry_t      w_head;

    // A redirect hides the head so decode never consumes a wrong-path entry
    // in the same cycle the queue is flushed.
    assign deq_valid = !w_empty && !redirect_valid;
    assign w_pop     = deq_valid && deq_ready;

    // A full queue may still accept when the head leaves this cycle.
    assign w_enq     = !redirect_valid && (!w_full || w_pop);

    assign w_is_jmp  = is_uncond_jmp(imem_ins);

    assign w_entry.pc  = imem_addr;
    assign w_entry.ins = imem_ins;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_enq) begin
            // The jump itself is still queued; only the next fetch address
            // changes.
            if (w_is_jmp) begin
                r_pc <= imem_ins[ADDR_W-1:0];
            end else begin
                r_pc <= r_pc + ADDR_W'(1);
            end
        end
    end

    assign imem_addr = r_pc;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (w_enq),
        .push_data (w_entry),
        .pop       (w_pop),
        .head_data (w_head),
        .empty     (w_empty),
        .full      (w_full)
    );

    assign deq_ins = w_head.ins;
    assign deq_pc  = w_head.pc;

endmodule : instruction_fetch_unit
`default_nettype wire
